// File: rtl/i2s_rx_frame_fifo_if.sv
// Frame stream handshake between the I2S receiver FIFO and its consumer.
// The receiver drives valid/data, the consumer drives ready.
interface i2s_rx_frame_fifo_if #(
    parameter int W = 48
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/i2s_rx_frame_fifo.sv
// Multi-lane I2S / left-justified receiver oversampled on the system clock.
// Complete stereo frames are buffered in a small FIFO and drained by valid/ready.
module i2s_rx_frame_fifo #(
    parameter int DATA_W     = 24,
    parameter int NUM_LANES  = 1,
    parameter int FORMAT     = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bck,
    input  logic                        lrck,
    input  logic [NUM_LANES-1:0]        sdata,
    i2s_rx_frame_fifo_if.master         stream,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        locked,
    output logic                        overflow,
    output logic                        short_word,
    input  logic                        clr_err
);
    localparam int FW = 2 * NUM_LANES * DATA_W;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DW_C    = CW'(DATA_W);
    localparam logic [CW-1:0] LAST    = CW'(DATA_W - 1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef logic [NUM_LANES-1:0][DATA_W-1:0] lanes_t;

    logic [1:0]           bck_sync;
    logic                 bck_d;
    logic [1:0]           lr_sync;
    logic [NUM_LANES-1:0] sd_s1;
    logic [NUM_LANES-1:0] sd_s2;
    logic                 rise;
    logic                 lr_edge;
    logic                 have_prev;
    logic                 lr_prev;
    logic                 active;
    logic                 chan;
    logic                 left_ok;
    logic [CW-1:0]        cnt;
    lanes_t               cur;
    lanes_t               hold_l;

    logic [CW-1:0]        nxt_cnt;
    lanes_t               nxt_cur;
    logic                 nxt_active;
    logic                 nxt_chan;
    logic                 fin;
    logic                 fin_short;
    lanes_t               fin_word;
    logic [FW-1:0]        frame;

    logic                 push_req;
    logic [FW-1:0]        push_data;
    logic [FW-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;
    logic                 pop;
    logic                 full;
    logic                 accept;

    // Place one serial bit at the position the bit counter points to (MSB first).
    function automatic logic [DATA_W-1:0] put(
        input logic [DATA_W-1:0] w,
        input logic [CW-1:0]     c,
        input logic              b
    );
        put = w;
        for (int i = 0; i < DATA_W; i++) begin
            if (c == CW'(DATA_W - 1 - i)) put[i] = b;
        end
    endfunction

    assign rise    = bck_sync[1] & ~bck_d;
    assign lr_edge = rise & have_prev & (lr_sync[1] != lr_prev);

    // Word assembly: slot start, bit capture, natural or truncated completion.
    always_comb begin
        nxt_cur    = cur;
        nxt_cnt    = cnt;
        nxt_active = active;
        nxt_chan   = chan;
        fin        = 1'b0;
        fin_short  = 1'b0;
        fin_word   = cur;
        if (lr_edge) begin
            if (active && cnt < DW_C) begin
                fin = 1'b1;
                for (int n = 0; n < NUM_LANES; n++) begin
                    fin_word[n] = (FORMAT == 0) ? put(cur[n], cnt, sd_s2[n]) : cur[n];
                end
                fin_short = (FORMAT != 0) || (cnt != LAST);
            end
            nxt_active = 1'b1;
            nxt_chan   = lr_sync[1];
            nxt_cnt    = '0;
            nxt_cur    = '0;
            if (FORMAT != 0) begin
                for (int n = 0; n < NUM_LANES; n++) begin
                    nxt_cur[n] = put('0, '0, sd_s2[n]);
                end
                nxt_cnt = CW'(1);
            end
        end else if (rise && active && cnt < DW_C) begin
            for (int n = 0; n < NUM_LANES; n++) begin
                nxt_cur[n] = put(cur[n], cnt, sd_s2[n]);
            end
            nxt_cnt = cnt + 1'b1;
            if (cnt == LAST) begin
                fin      = 1'b1;
                fin_word = nxt_cur;
            end
        end
    end

    // Frame layout per lane: right word above left word.
    always_comb begin
        frame = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            frame[2*n*DATA_W +: DATA_W]     = hold_l[n];
            frame[(2*n+1)*DATA_W +: DATA_W] = fin_word[n];
        end
    end

    // Synchronisers, lock tracking, word registers and frame hand-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            bck_sync   <= '0;
            bck_d      <= 1'b0;
            lr_sync    <= '0;
            sd_s1      <= '0;
            sd_s2      <= '0;
            have_prev  <= 1'b0;
            lr_prev    <= 1'b0;
            locked     <= 1'b0;
            active     <= 1'b0;
            chan       <= 1'b0;
            cnt        <= '0;
            cur        <= '0;
            hold_l     <= '0;
            left_ok    <= 1'b0;
            push_req   <= 1'b0;
            push_data  <= '0;
            short_word <= 1'b0;
        end else begin
            bck_sync <= {bck_sync[0], bck};
            bck_d    <= bck_sync[1];
            lr_sync  <= {lr_sync[0], lrck};
            sd_s1    <= sdata;
            sd_s2    <= sd_s1;
            cur      <= nxt_cur;
            cnt      <= nxt_cnt;
            active   <= nxt_active;
            chan     <= nxt_chan;
            push_req <= 1'b0;
            if (rise) begin
                lr_prev   <= lr_sync[1];
                have_prev <= 1'b1;
            end
            if (lr_edge) locked <= 1'b1;
            if (fin && !chan) begin
                hold_l  <= fin_word;
                left_ok <= 1'b1;
            end
            if (fin && chan) begin
                left_ok <= 1'b0;
                if (left_ok) begin
                    push_req  <= 1'b1;
                    push_data <= frame;
                end
            end
            if (clr_err) short_word <= 1'b0;
            if (fin && fin_short) short_word <= 1'b1;
        end
    end

    assign pop    = stream.out_valid & stream.out_ready;
    assign full   = (count == DEPTH_C);
    assign accept = push_req & (~full | pop);

    // Frame FIFO; a push into a full FIFO survives only if a pop frees the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
            if (clr_err) overflow <= 1'b0;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    assign stream.out_valid = (count != '0);
    assign stream.out_data  = mem[rd_ptr];
    assign fifo_level       = count;
endmodule

// File: tb/tb_i2s_rx_frame_fifo.sv
// Directed bench for i2s_rx_frame_fifo: I2S 24-bit single lane plus a
// left-justified 16-bit dual-lane instance, with FIFO corner sequences.
module tb_i2s_rx_frame_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       bck, lrck, sdata;
    logic       bck2, lrck2;
    logic [1:0] sdata2;
    logic       ready1, ready2;
    logic [3:0] level1, level2;
    logic       locked1, locked2, ovf1, ovf2, short1, short2;
    logic       carry;
    int         total = 0;
    int         passed = 0;

    logic [47:0] q1[$];
    logic [63:0] q2[$];

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          ls;
        int          rs;
        logic [47:0] exp;
        logic        exp_short;
    } vec_t;
    vec_t tv[6];

    always #5 clk = ~clk;

    i2s_rx_frame_fifo_if #(.W(48)) s1 ();
    i2s_rx_frame_fifo_if #(.W(64)) s2 ();
    assign s1.out_ready = ready1;
    assign s2.out_ready = ready2;

    i2s_rx_frame_fifo #(
        .DATA_W(24), .NUM_LANES(1), .FORMAT(0), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .bck(bck), .lrck(lrck), .sdata(sdata),
        .stream(s1), .fifo_level(level1), .locked(locked1),
        .overflow(ovf1), .short_word(short1), .clr_err(clr)
    );

    i2s_rx_frame_fifo #(
        .DATA_W(16), .NUM_LANES(2), .FORMAT(1), .FIFO_DEPTH(8)
    ) dut2 (
        .clk(clk), .reset(reset), .bck(bck2), .lrck(lrck2), .sdata(sdata2),
        .stream(s2), .fifo_level(level2), .locked(locked2),
        .overflow(ovf2), .short_word(short2), .clr_err(clr)
    );

    // Record every accepted frame, sampled mid-cycle before the popping edge.
    always @(negedge clk) begin
        if (!reset && s1.out_valid && ready1) q1.push_back(s1.out_data);
        if (!reset && s2.out_valid && ready2) q2.push_back(s2.out_data);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One I2S slot; mode 1 measures clocks from the LSB rise to out_valid,
    // mode 2 pulses out_ready exactly in the push cycle of that LSB.
    task automatic i2s_slot(input logic lr, input logic [23:0] w, input int s,
                            input int mode, output int lat);
        lat = 0;
        for (int k = 0; k < s; k++) begin
            logic d;
            d = 1'b0;
            if (k == 0) d = carry;
            else if (k <= 24) d = w[24-k];
            bck = 1'b0; lrck = lr; sdata = d;
            #40;
            bck = 1'b1;
            if (mode != 0 && k == 24) begin
                for (int n = 1; n <= 8 && lat == 0; n++) begin
                    @(posedge clk); #1;
                    if (mode == 1 && s1.out_valid) lat = n;
                    if (mode == 2 && n == 3) ready1 = 1'b1;
                    if (mode == 2 && n == 4) begin
                        ready1 = 1'b0;
                        lat = n;
                    end
                end
                @(negedge clk);
            end else begin
                #40;
            end
        end
        carry = (s <= 24) ? w[24-s] : 1'b0;
    endtask

    task automatic i2s_frame(input logic [23:0] l, input logic [23:0] r);
        int lat;
        i2s_slot(1'b0, l, 32, 0, lat);
        i2s_slot(1'b1, r, 32, 0, lat);
    endtask

    task automatic lj_slot(input logic lr, input logic [15:0] w0, input logic [15:0] w1,
                           input int s);
        for (int k = 0; k < s; k++) begin
            logic [1:0] d;
            d = '0;
            if (k < 16) d = {w1[15-k], w0[15-k]};
            bck2 = 1'b0; lrck2 = lr; sdata2 = d;
            #40;
            bck2 = 1'b1;
            #40;
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #1 ready1 = v;
        @(negedge clk);
    endtask

    task automatic wait_q1(input int n);
        for (int i = 0; i < 400 && q1.size() < n; i++) @(posedge clk);
        chk("q1_count", 64'(q1.size()), 64'(n));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [47:0] f;

        tv[0] = '{24'hA5A5A5, 24'h5A5A5A, 32, 32, 48'h5A5A5A_A5A5A5, 1'b0};
        tv[1] = '{24'hFFFFFF, 24'h000001, 32, 32, 48'h000001_FFFFFF, 1'b0};
        tv[2] = '{24'h800000, 24'h7FFFFF, 32, 32, 48'h7FFFFF_800000, 1'b0};
        tv[3] = '{24'h123456, 24'hABCDEF, 20, 32, 48'hABCDEF_123450, 1'b1};
        tv[4] = '{24'hC3C3C3, 24'h3C3C3D, 24, 24, 48'h3C3C3D_C3C3C3, 1'b0};
        tv[5] = '{24'h000000, 24'hFFFFFF, 25, 32, 48'hFFFFFF_000000, 1'b0};

        reset = 1'b1; clr = 1'b0; carry = 1'b0;
        bck = 1'b0; lrck = 1'b1; sdata = 1'b0;
        bck2 = 1'b0; lrck2 = 1'b1; sdata2 = '0;
        ready1 = 1'b1; ready2 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(s1.out_valid), 64'd0);
        chk("rst_data", 64'(s1.out_data), 64'd0);
        chk("rst_level", 64'(level1), 64'd0);
        chk("rst_locked", 64'(locked1), 64'd0);
        chk("rst_overflow", 64'(ovf1), 64'd0);
        chk("rst_short", 64'(short1), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // I2S vectors, including truncated and exactly-DATA_W slots
        i2s_slot(1'b1, 24'h0, 32, 0, lat);
        chk("prelock_locked", 64'(locked1), 64'd0);
        for (int i = 0; i < 6; i++) begin
            i2s_slot(1'b0, tv[i].l, tv[i].ls, 0, lat);
            i2s_slot(1'b1, tv[i].r, tv[i].rs, 0, lat);
            chk($sformatf("short_%0d", i), 64'(short1), 64'(tv[i].exp_short));
            pulse_clr();
        end
        chk("short_cleared", 64'(short1), 64'd0);
        i2s_slot(1'b0, 24'h0F0F0F, 32, 0, lat);
        i2s_slot(1'b1, 24'hF0F0F0, 32, 1, lat);
        chk("valid_latency", 64'(lat), 64'd4);
        wait_q1(7);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("frame_%0d", i), 64'(q1[i]), 64'(tv[i].exp));
        end
        chk("frame_lat", 64'(q1[6]), 64'h0000_F0F0F0_0F0F0F);

        // Left-justified, two lanes
        lj_slot(1'b1, 16'h0, 16'h0, 32);
        lj_slot(1'b0, 16'h1234, 16'hFFFF, 32);
        lj_slot(1'b1, 16'h8001, 16'h0000, 32);
        for (int i = 0; i < 40 && q2.size() < 1; i++) @(posedge clk);
        chk("lj_count", 64'(q2.size()), 64'd1);
        chk("lj_frame", q2[0], 64'h0000_FFFF_8001_1234);
        chk("lj_locked", 64'(locked2), 64'd1);
        chk("lj_short", 64'(short2), 64'd0);
        @(negedge clk);

        // Overflow: 10 frames into a stalled FIFO
        q1.delete();
        set_ready(1'b0);
        for (int i = 0; i < 10; i++) i2s_frame(24'h100000 | 24'(i), 24'h200000 | 24'(i));
        repeat (6) @(posedge clk);
        #1;
        chk("ovf_level", 64'(level1), 64'd8);
        chk("ovf_flag", 64'(ovf1), 64'd1);
        chk("ovf_valid", 64'(s1.out_valid), 64'd1);
        chk("ovf_stable_data", 64'(s1.out_data), 64'h200000_100000);
        @(negedge clk);
        pulse_clr();
        chk("ovf_cleared", 64'(ovf1), 64'd0);
        set_ready(1'b1);
        wait_q1(8);
        for (int i = 0; i < 8; i++) begin
            f = {24'h200000 | 24'(i), 24'h100000 | 24'(i)};
            chk($sformatf("drain_%0d", i), 64'(q1[i]), 64'(f));
        end
        chk("drain_level", 64'(level1), 64'd0);

        // Full FIFO with push and pop in the same cycle
        q1.delete();
        set_ready(1'b0);
        for (int i = 0; i < 8; i++) i2s_frame(24'h300000 | 24'(i), 24'h400000 | 24'(i));
        repeat (6) @(posedge clk);
        #1;
        chk("full_level", 64'(level1), 64'd8);
        @(negedge clk);
        i2s_slot(1'b0, 24'h300008, 32, 0, lat);
        i2s_slot(1'b1, 24'h400008, 32, 2, lat);
        repeat (3) @(posedge clk);
        #1;
        chk("pp_overflow", 64'(ovf1), 64'd0);
        chk("pp_level", 64'(level1), 64'd8);
        @(negedge clk);
        set_ready(1'b1);
        wait_q1(9);
        for (int i = 0; i < 9; i++) begin
            f = {24'h400000 | 24'(i), 24'h300000 | 24'(i)};
            chk($sformatf("wrap_%0d", i), 64'(q1[i]), 64'(f));
        end

        // Reset in the middle of a right slot with a frame still buffered
        q1.delete();
        set_ready(1'b0);
        i2s_frame(24'h111111, 24'h222222);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_level", 64'(level1), 64'd1);
        @(negedge clk);
        i2s_slot(1'b0, 24'h333333, 32, 0, lat);
        i2s_slot(1'b1, 24'h444444, 10, 0, lat);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_level", 64'(level1), 64'd0);
        chk("midrst_locked", 64'(locked1), 64'd0);
        chk("midrst_valid", 64'(s1.out_valid), 64'd0);
        reset = 1'b0;
        ready1 = 1'b1;
        @(negedge clk);
        i2s_slot(1'b1, 24'h444444, 22, 0, lat);
        chk("relock_before_edge", 64'(locked1), 64'd0);
        i2s_slot(1'b0, 24'h555555, 32, 0, lat);
        chk("relock_after_edge", 64'(locked1), 64'd1);
        i2s_slot(1'b1, 24'h666666, 32, 0, lat);
        wait_q1(1);
        chk("relock_frame", 64'(q1[0]), 64'h666666_555555);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
